// File: rtl/elbeth_dmem_responder.sv
// Data-memory responder for the execute-stage request/ready handshake.
// It latches a request, waits LATENCY cycles, then performs a byte, half or word access.
module elbeth_dmem_responder #(
    parameter int ADDR_WIDTH  = 32,
    parameter int DEPTH_WORDS = 1024,
    parameter int LATENCY     = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [ADDR_WIDTH-1:0] dmem_addr,
    input  logic [31:0]           dmem_data_w,
    input  logic                  dmem_en,
    input  logic                  dmem_wr,
    input  logic [1:0]            dmem_size,
    input  logic                  dmem_sign,
    output logic [31:0]           dmem_data_r,
    output logic                  dmem_ready,
    output logic                  dmem_error
);

    localparam int IDX_W = $clog2(DEPTH_WORDS);
    localparam logic [ADDR_WIDTH:0] BYTE_LIMIT = (ADDR_WIDTH + 1)'(4 * DEPTH_WORDS);
    localparam logic [3:0] CNT_INIT = 4'(LATENCY - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_RESP
    } state_t;

    state_t                state_q;
    logic [3:0]            cnt_q;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [31:0]           wdata_q;
    logic                  wr_q;
    logic [1:0]            size_q;
    logic                  sign_q;
    logic                  ready_q;
    logic                  error_q;
    logic [31:0]           rdata_q;

    logic [31:0] mem_q [DEPTH_WORDS];

    logic                  in_idle;
    logic [ADDR_WIDTH-1:0] addr_d;
    logic [31:0]           wdata_d;
    logic                  wr_d;
    logic [1:0]            size_d;
    logic                  sign_d;
    logic                  go_resp_d;
    logic                  err_d;
    logic [IDX_W-1:0]      idx_d;
    logic [31:0]           word_rd;
    logic [7:0]            lane_b;
    logic [15:0]           lane_h;
    logic [31:0]           load_d;
    logic [3:0]            be_d;
    logic [31:0]           wword_d;

    // With LATENCY=1 the access happens on the accepting edge, so use the live request there.
    assign in_idle   = (state_q == S_IDLE);
    assign addr_d    = in_idle ? dmem_addr   : addr_q;
    assign wdata_d   = in_idle ? dmem_data_w : wdata_q;
    assign wr_d      = in_idle ? dmem_wr     : wr_q;
    assign size_d    = in_idle ? dmem_size   : size_q;
    assign sign_d    = in_idle ? dmem_sign   : sign_q;

    assign go_resp_d = (in_idle && dmem_en && (LATENCY == 1))
                    || ((state_q == S_WAIT) && (cnt_q == 4'd1));

    assign err_d = ((size_d == 2'd1) && addr_d[0])
                || ((size_d == 2'd2) && (addr_d[1:0] != 2'b00))
                || (size_d == 2'd3)
                || ({1'b0, addr_d} >= BYTE_LIMIT);

    assign idx_d   = addr_d[IDX_W+1:2];
    assign word_rd = mem_q[idx_d];
    assign lane_b  = 8'(word_rd >> {addr_d[1:0], 3'b000});
    assign lane_h  = 16'(word_rd >> {addr_d[1], 4'b0000});

    always_comb begin
        load_d  = word_rd;
        be_d    = 4'b0000;
        wword_d = wdata_d;
        unique case (size_d)
            2'd0: begin
                load_d  = {{24{sign_d & lane_b[7]}}, lane_b};
                be_d    = 4'b0001 << addr_d[1:0];
                wword_d = {4{wdata_d[7:0]}};
            end
            2'd1: begin
                load_d  = {{16{sign_d & lane_h[15]}}, lane_h};
                be_d    = addr_d[1] ? 4'b1100 : 4'b0011;
                wword_d = {2{wdata_d[15:0]}};
            end
            2'd2: begin
                load_d  = word_rd;
                be_d    = 4'b1111;
                wword_d = wdata_d;
            end
            default: begin
                load_d  = 32'h0;
                be_d    = 4'b0000;
                wword_d = wdata_d;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst && go_resp_d && wr_d && !err_d) begin
            for (int i = 0; i < 4; i++) begin
                if (be_d[i]) begin
                    mem_q[idx_d][8*i +: 8] <= wword_d[8*i +: 8];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= 4'd0;
            ready_q <= 1'b0;
            error_q <= 1'b0;
            rdata_q <= 32'h0;
            addr_q  <= '0;
            wdata_q <= 32'h0;
            wr_q    <= 1'b0;
            size_q  <= 2'd0;
            sign_q  <= 1'b0;
        end else begin
            ready_q <= go_resp_d;
            error_q <= go_resp_d && err_d;
            rdata_q <= (go_resp_d && !err_d && !wr_d) ? load_d : 32'h0;
            unique case (state_q)
                S_IDLE: begin
                    if (dmem_en) begin
                        addr_q  <= dmem_addr;
                        wdata_q <= dmem_data_w;
                        wr_q    <= dmem_wr;
                        size_q  <= dmem_size;
                        sign_q  <= dmem_sign;
                        cnt_q   <= CNT_INIT;
                        state_q <= (LATENCY == 1) ? S_RESP : S_WAIT;
                    end
                end
                S_WAIT: begin
                    cnt_q <= cnt_q - 4'd1;
                    if (cnt_q == 4'd1) begin
                        state_q <= S_RESP;
                    end
                end
                S_RESP: begin
                    state_q <= S_IDLE;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign dmem_ready  = ready_q;
    assign dmem_error  = error_q;
    assign dmem_data_r = rdata_q;

endmodule
